// File: rtl/uart_tx_fifo_param.sv
// UART transmitter fed by a small word FIFO: start, LSB-first data, optional parity,
// one or two stop bits, frames sent back-to-back while words are queued.
module uart_tx_fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          DATA_VALID,
  output logic                          DATA_READY,
  input  logic [PRESCALE_W-1:0]         PRESCALE,
  input  logic                          PAR_ENABLE,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  output logic                          TX_OUT,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  par_q, par_en_q, stop2_q;
  logic [PRESCALE_W-1:0] pm1_q, pm1_in, cyc_q;
  logic [BW-1:0]         bit_q;
  logic                  tx_q, busy_q, tx_d;
  logic                  push, pop, bit_end;

  assign DATA_READY = (count_q != CW'(FIFO_DEPTH));
  assign push       = DATA_VALID & DATA_READY;
  assign bit_end    = (cyc_q == '0);
  // A zero bit period behaves as one cycle per bit
  assign pm1_in     = (PRESCALE == '0) ? '0 : PRESCALE - PRESCALE_W'(1);

  assign TX_OUT     = tx_q;
  assign BUSY       = busy_q;
  assign FIFO_COUNT = count_q;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, FIFO pop strobe and the line level for the current state
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shreg_q[0];
        if (bit_end && bit_q == BW'(DATA_WIDTH - 1))
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_d = par_q;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end && bit_q == BW'(stop2_q)) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= P_DATA;
  end

  // FIFO pointers/occupancy, frame config latch, bit timing and registered line outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      pm1_q    <= '0;
      cyc_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (pop) begin
        shreg_q  <= mem[rd_ptr_q];
        par_q    <= (^mem[rd_ptr_q]) ^ PAR_TYP;
        par_en_q <= PAR_ENABLE;
        stop2_q  <= STOP2;
        pm1_q    <= pm1_in;
        cyc_q    <= pm1_in;
      end else begin
        if (state_q == DATA && bit_end) shreg_q <= shreg_q >> 1;
        if (state_q != IDLE) cyc_q <= bit_end ? pm1_q : cyc_q - PRESCALE_W'(1);
      end

      if (state_d != state_q)
        bit_q <= '0;
      else if (bit_end && (state_q == DATA || state_q == STOP))
        bit_q <= bit_q + BW'(1);

      tx_q   <= tx_d;
      busy_q <= (state_q != IDLE);
    end
  end

endmodule
